mul_hilo_ctrl: RTL and testbench
================================

Name: mul_hilo_ctrl

Overview:
- Downstream stage of the 32-bit shift-add multiplier.
- Sequences one multiply run after firstart:
  - counts multiplier iterations;
  - captures the 64-bit product into HI/LO on completion;
  - serves MFHI/MFLO reads via the 6-bit funct code (Signal).
- Sits between the multiplier product bus and the ALU result mux.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH, product 2*WIDTH.
- CYCLES, 32, multiplier iterations required before the product is valid.
- F_MULTU, 6'd25, funct code that permits capture of the product.
- F_MFHI, 6'd16, funct code selecting HI on dataOut.
- F_MFLO, 6'd18, funct code selecting LO on dataOut.

Ports:
- clk  input  1  system clock; this block acts on posedge, multiplier iterates on negedge.
- firstart  input  1  reset, asynchronous, active-high; its deassertion starts a new run.
- Signal  input  6  funct code of the current instruction.
- prodIn  input  2*WIDTH  multiplier running product {hi,lo}.
- dataOut  output  WIDTH  selected HI/LO read value.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  run in progress.
- done  output  1  run finished; HI/LO hold the captured result.

Behaviour:
- Reset (firstart high, asynchronous, overrides everything):
  - state=RUN, count=0, hi=0, lo=0, done=0, busy=1.
  - Held for as long as firstart is high.
- States: RUN and DONE.
  - RUN: on each posedge clk, if count<CYCLES then count<=count+1.
  - RUN to DONE: at the posedge where count==CYCLES.
    - This guarantees at least CYCLES multiplier negedges since firstart fell, whatever the clk phase at deassertion.
    - At that edge, if Signal==F_MULTU: {hi,lo}<=prodIn.
    - Otherwise hi/lo keep their value (0 after reset); the run still completes.
  - DONE: absorbing. busy=0, done=1, count holds at CYCLES. prodIn is ignored; further multiplier negedges do not alter hi/lo.
  - Only firstart leaves DONE.
- Latency: capture on posedge CYCLES+1 after firstart deasserts; done/busy change at that same edge.
- count: $clog2(CYCLES+1) bits; never wraps.
- busy = (state==RUN); done = (state==DONE); both registered-state decodes, no glitch paths from Signal.
- dataOut is combinational from registered hi/lo:
  - Signal==F_MFHI gives hi.
  - Signal==F_MFLO gives lo.
  - Any other code gives 0.
  - Valid in any state; a read during RUN returns the pre-run (cleared) value.
- Boundary conditions:
  - firstart asserted mid-run: immediate abort. count=0 and hi/lo=0; no partial capture.
  - Signal changes during RUN: only its value at the capture edge matters.
  - Signal==F_MULTU while already in DONE: no effect.
  - Full-scale product (all ones × all ones) captured without truncation: 2*WIDTH bits, no carry out.

Decomposition:
- Shared package mul_pkg:
  - funct constants F_MULTU/F_MFHI/F_MFLO;
  - state enum {RUN, DONE};
  - CYCLES default.
- Sub-module hilo_reg: two WIDTH-bit registers with async clear, load enable, and read mux. The sequencer and counter stay in mul_hilo_ctrl.

Test Plan:
- Bench: multiplier instance or behavioural model drives prodIn; clk period 10 ns.
- Operands 7×6, Signal=F_MULTU, pulse firstart:
  - busy=1 for 32 posedges;
  - at posedge 33: lo=42, hi=0, done=1, busy=0.
- 0xFFFFFFFF×0xFFFFFFFF, F_MULTU:
  - hi=0xFFFFFFFE, lo=0x00000001 at capture;
  - then Signal=F_MFHI gives dataOut=0xFFFFFFFE, Signal=F_MFLO gives 0x00000001, Signal=0 gives 0.
- Reassert firstart at count==10 during a 3×5 run:
  - hi/lo/count/done clear asynchronously (before the next clk edge);
  - a fresh run then captures lo=15 at posedge 33 after the second deassertion.
- Signal=6'd0 at capture edge for 9×9:
  - done=1 at posedge 33, hi=lo=0 (no capture).
- After DONE with lo=42, leave clk running 100 cycles while prodIn changes:
  - hi/lo stay 0/42, done stays 1;
  - deasserting firstart alone does not restart; a new firstart pulse is required.
- Deassert firstart while clk high, and in a second run while clk low:
  - capture occurs on posedge 33 in both cases, with the correct product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier HI/LO control slice:
// funct codes, sequencer state encoding and default iteration count.
package mul_pkg;

    localparam int unsigned CYCLES_DEF = 32;

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// HI/LO register pair with async clear, load enable and funct read mux.
// Ports: clk_i, clr_i (async, high), ld_i, hi_d_i/lo_d_i, sel_i -> hi_o, lo_o, rd_o.
module hilo_reg
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter logic [5:0]  SEL_HI = F_MFHI,
    parameter logic [5:0]  SEL_LO = F_MFLO
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] hi_d_i,
    input  logic [WIDTH-1:0] lo_d_i,
    input  logic [5:0]       sel_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] rd_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (ld_i) begin
            hi_d = hi_d_i;
            lo_d = lo_d_i;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        rd_o = '0;
        if (sel_i == SEL_HI)
            rd_o = hi_q;
        else if (sel_i == SEL_LO)
            rd_o = lo_q;
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multiplier downstream stage: counts iterations after firstart, captures
// the product into HI/LO, serves MFHI/MFLO. Ports: clk, firstart, Signal,
// prodIn -> dataOut, hi, lo, busy, done.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CYCLES  = CYCLES_DEF,
    parameter logic [5:0]  F_MULTU = mul_pkg::F_MULTU,
    parameter logic [5:0]  F_MFHI  = mul_pkg::F_MFHI,
    parameter logic [5:0]  F_MFLO  = mul_pkg::F_MFLO
) (
    input  logic               clk,
    input  logic               firstart,
    input  logic [5:0]         Signal,
    input  logic [2*WIDTH-1:0] prodIn,
    output logic [WIDTH-1:0]   dataOut,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          load;

    // Terminal count is checked one edge after it is reached, so at least
    // CYCLES multiplier negedges separate firstart release from capture.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        case (state_q)
            RUN: begin
                if (count_q == CMAX) begin
                    state_d = DONE;
                    load    = (Signal == F_MULTU);
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge firstart) begin
        if (firstart) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    hilo_reg #(
        .WIDTH  (WIDTH),
        .SEL_HI (F_MFHI),
        .SEL_LO (F_MFLO)
    ) u_hilo (
        .clk_i  (clk),
        .clr_i  (firstart),
        .ld_i   (load),
        .hi_d_i (prodIn[2*WIDTH-1:WIDTH]),
        .lo_d_i (prodIn[WIDTH-1:0]),
        .sel_i  (Signal),
        .hi_o   (hi),
        .lo_o   (lo),
        .rd_o   (dataOut)
    );

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: behavioural shift-add multiplier on negedge
// feeds prodIn; expected HI/LO come from plain 64-bit multiplication.
module tb_mul_hilo_ctrl;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        firstart = 1'b1;
    logic [5:0]  Signal = 6'd0;
    logic [63:0] prodIn;
    logic [31:0] dataOut, hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    mul_hilo_ctrl dut (
        .clk      (clk),
        .firstart (firstart),
        .Signal   (Signal),
        .prodIn   (prodIn),
        .dataOut  (dataOut),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // multiplier model: iterates on negedge, stops itself after 32 steps
    logic [31:0] ma = 32'd0, mb = 32'd0;
    logic [63:0] mp;
    logic [32:0] msum;
    int          mcnt;
    bit          scramble = 1'b0;

    always @(negedge clk or posedge firstart) begin
        if (firstart) begin
            mp   <= {32'd0, mb};
            mcnt <= 0;
        end else if (scramble) begin
            mp <= {$urandom, $urandom};
        end else if (mcnt < 32) begin
            msum = {1'b0, mp[63:32]} + (mp[0] ? {1'b0, ma} : 33'd0);
            mp   <= {msum, mp[31:1]};
            mcnt <= mcnt + 1;
        end
    end

    assign prodIn = mp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    // pulse firstart, check reset state, release in the chosen clk phase
    task automatic start_run(input logic [31:0] a, input logic [31:0] b,
                             input bit rel_high);
        scramble = 1'b0;
        ma = a;
        mb = b;
        Signal = 6'($urandom_range(0, 63));
        firstart = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_cnt", 64'(dut.count_q), 64'd0);
        if (rel_high) begin
            @(posedge clk);
            #2;
        end else begin
            @(negedge clk);
            #2;
        end
        firstart = 1'b0;
    endtask

    // run 32 posedges in RUN, then expect capture/no-capture on edge 33
    task automatic finish_run(input logic [5:0] sig);
        logic [63:0] p;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_done", 64'(done), 64'd0);
            if (k == 16) begin
                Signal = F_MFHI;
                #1;
                chk("run_rd", 64'(dataOut), 64'd0);
            end
            Signal = (k == 32) ? sig : 6'($urandom_range(0, 63));
        end
        @(posedge clk);
        #1;
        p = (sig == F_MULTU) ? ref_prod(ma, mb) : 64'd0;
        chk("cap_done", 64'(done), 64'd1);
        chk("cap_busy", 64'(busy), 64'd0);
        chk("cap_hi", 64'(hi), {32'd0, p[63:32]});
        chk("cap_lo", 64'(lo), {32'd0, p[31:0]});
    endtask

    task automatic rd(input logic [5:0] sig, input logic [31:0] exp);
        Signal = sig;
        #1;
        chk("read", 64'(dataOut), 64'(exp));
    endtask

    initial begin
        // 7 x 6 captured, then DONE must hold against noise
        start_run(32'd7, 32'd6, 1'b0);
        finish_run(F_MULTU);
        scramble = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            Signal = (c % 3 == 0) ? F_MULTU : 6'($urandom_range(0, 63));
            if (c % 25 == 24) begin
                chk("hold_lo", 64'(lo), 64'd42);
                chk("hold_hi", 64'(hi), 64'd0);
                chk("hold_done", 64'(done), 64'd1);
            end
        end
        firstart = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("norestart_done", 64'(done), 64'd1);
        chk("norestart_lo", 64'(lo), 64'd42);

        // full-scale, release while clk high
        start_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_run(F_MULTU);
        rd(F_MFHI, 32'hFFFF_FFFE);
        rd(F_MFLO, 32'h0000_0001);
        rd(6'd0, 32'd0);

        // abort at count 10, then a fresh 3 x 5 run
        start_run(32'd3, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_abort_cnt", 64'(dut.count_q), 64'd10);
        firstart = 1'b1;
        #1;
        chk("abort_cnt", 64'(dut.count_q), 64'd0);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        start_run(32'd3, 32'd5, 1'b1);
        finish_run(F_MULTU);
        chk("rerun_lo", 64'(lo), 64'd15);

        // no capture when funct is not MULTU at the edge
        start_run(32'd9, 32'd9, 1'b0);
        finish_run(6'd0);

        // random operands, phases and capture codes
        for (int r = 0; r < 6; r++) begin
            start_run($urandom, $urandom, 1'($urandom_range(0, 1)));
            finish_run((r % 3 == 2) ? 6'($urandom_range(0, 24))
                                    : F_MULTU);
            rd(F_MFHI, hi);
            rd(F_MFLO, lo);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
